dll_delay_cal: RTL and testbench
================================

# dll_delay_cal

Synthesizable calibration controller for the DQS delay path. It sweeps a delay-line tap code until the phase detector reports that the delayed clock has reached a half-period offset, then derives the quarter-period code. It asserts DQSDEL so the downstream delay cells apply the quarter-period shift. It sits on the master side of the DLL delay cells: it produces the DQSDEL enable and the delay code that those cells consume.

## Interface
Parameters:
- CODE_W, 7: width of tap codes; the maximum code is 2^CODE_W-1.
- SETTLE_CYC, 4: cycles to wait after each code change before sampling; minimum 3, to cover the input synchronizer.
- TRACK_INTERVAL, 64: cycles between tracking adjustments in LOCKED (used only with tracking compiled in).

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- CAL_START  in  1  one-cycle pulse; starts or restarts calibration.
- PHASE_IN  in  1  phase detector output (asynchronous); 1 means the delay at HALF_CODE is at or beyond half a period. Two-flop synchronized internally to phase_s.
- HOLD  in  1  freezes tracking updates while high.
- HALF_CODE  out  CODE_W  tap code driven to the measurement delay line.
- DEL_CODE  out  CODE_W  quarter-period code for the DQS delay cells.
- DQSDEL  out  1  delay enable to the delay cells; equal to LOCK.
- LOCK  out  1  calibration valid.
- ERR  out  1  calibration failed.
- BUSY  out  1  sweep in progress (SETTLE or CHECK).

## Operation
- States: IDLE, SETTLE, CHECK, LOCKED, FAIL.
- Reset: state IDLE; HALF_CODE, DEL_CODE, DQSDEL, LOCK, ERR and BUSY all 0; settle and interval counters 0; synchronizer flops 0.
- IDLE:
  - CAL_START=1 -> SETTLE, HALF_CODE=0, settle counter loaded with SETTLE_CYC-1.
- SETTLE:
  - Counter decrements once per cycle.
  - At 0 -> CHECK.
- CHECK (one cycle), evaluated on phase_s:
  - phase_s=1 and HALF_CODE=0 -> FAIL (the detector was already past half a period at zero delay).
  - phase_s=1 and HALF_CODE=N>0 -> LOCKED; DEL_CODE=(N+1)>>1, computed in CODE_W+1 bits (round half up).
  - phase_s=0 and HALF_CODE=max -> FAIL.
  - Otherwise HALF_CODE++ and -> SETTLE with the counter reloaded.
- LOCKED: LOCK=1, DQSDEL=1, BUSY=0. Tracking runs only if compiled in (see Configuration).
- FAIL:
  - ERR=1, LOCK=0, DQSDEL=0.
  - HALF_CODE holds its last value; DEL_CODE=0.
- CAL_START=1 in any state, including mid-sweep, LOCKED and FAIL:
  - Immediate restart: LOCK, DQSDEL and ERR cleared on the same edge, HALF_CODE=0, -> SETTLE.
- RST has priority over CAL_START.
- RST mid-sweep aborts the sweep and returns every output to its reset value.

## Timing
- Each sweep step takes SETTLE_CYC+1 cycles.
- With CAL_START sampled at edge e0 and detection at HALF_CODE=N: LOCK, DQSDEL and DEL_CODE become valid after edge e0+(N+1)(SETTLE_CYC+1).
- BUSY is high from e0+1 until LOCK or ERR asserts.
- Stuck-low failure: ERR asserts after edge e0+2^CODE_W·(SETTLE_CYC+1).
- Stuck-high failure: ERR asserts after edge e0+SETTLE_CYC+1.
- PHASE_IN to phase_s latency is 2 cycles; SETTLE_CYC≥3 guarantees the sample in CHECK reflects the current HALF_CODE.
- DEL_CODE registers on the same edge as LOCK. Tracking updates HALF_CODE and DEL_CODE on the same edge.

## Configuration
- Macro DLLDELAY_CAL_TRACK_EN:
  - Defined: in LOCKED, an interval counter counts TRACK_INTERVAL cycles. At expiry, if HOLD=0:
    - phase_s=1 and HALF_CODE>1 -> HALF_CODE--.
    - phase_s=0 and HALF_CODE<max -> HALF_CODE++.
    - At a range limit the code saturates; ERR is not set.
    - DEL_CODE=(HALF_CODE+1)>>1, updated on the same edge.
    - The counter restarts at every expiry, whatever HOLD is.
  - Undefined: no interval counter. HALF_CODE and DEL_CODE stay frozen in LOCKED until CAL_START or RST. HOLD is ignored.

## Test plan
1. Reset: assert RST for 3 cycles -> all outputs 0, state IDLE; PHASE_IN toggling while in IDLE has no effect.
2. Lock: SETTLE_CYC=4, PHASE_IN=1 whenever HALF_CODE≥20, CAL_START at e0 -> LOCK=DQSDEL=1 after e0+105, HALF_CODE=20, DEL_CODE=10, BUSY=0. Repeat with threshold 21 -> DEL_CODE=11.
3. Failures:
   - PHASE_IN stuck 1 -> ERR=1 after e0+5, LOCK=0.
   - PHASE_IN stuck 0, CODE_W=7 -> ERR=1 after e0+640, HALF_CODE=127, DEL_CODE=0.
4. Tracking (macro defined): lock at 20, then hold PHASE_IN=0 -> HALF_CODE=21 and DEL_CODE=11 after the next 64-cycle expiry. Set HOLD=1 -> no change across 3 intervals. With the macro undefined, the codes never change.
5. Restart:
   - CAL_START at HALF_CODE=9 mid-sweep -> next edge HALF_CODE=0, BUSY=1; relocks per scenario 2 timing.
   - CAL_START in LOCKED -> LOCK=DQSDEL=0 on that edge.
6. RST mid-sweep at HALF_CODE=15 -> all outputs 0 next edge; a subsequent CAL_START performs a normal sweep.

Source files
------------

// File: rtl/dll_delay_cal.sv
// rtl/dll_delay_cal.sv - DQS delay-line calibration sweep producing the quarter-period code and DQSDEL
// Optional LOCKED-state tracking is compiled in with macro DLLDELAY_CAL_TRACK_EN.
module dll_delay_cal #(
  parameter int CODE_W         = 7,
  parameter int SETTLE_CYC     = 4,
  parameter int TRACK_INTERVAL = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CAL_START,
  input  logic              PHASE_IN,
  input  logic              HOLD,
  output logic [CODE_W-1:0] HALF_CODE,
  output logic [CODE_W-1:0] DEL_CODE,
  output logic              DQSDEL,
  output logic              LOCK,
  output logic              ERR,
  output logic              BUSY
);

  localparam int                SW          = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [CODE_W-1:0] CODE_MAX    = '1;
  localparam logic [CODE_W-1:0] CODE_ONE    = CODE_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic          phase_meta;
  logic          phase_s;

`ifdef DLLDELAY_CAL_TRACK_EN
  localparam int            TW         = $clog2(TRACK_INTERVAL + 1);
  localparam logic [TW-1:0] TRACK_LAST = TW'(TRACK_INTERVAL - 1);
  logic [TW-1:0] track_cnt;
`else
  localparam int unused_track_interval = TRACK_INTERVAL;
  logic unused_hold;
  assign unused_hold = HOLD;
`endif

  // Quarter-period code: half code rounded half up, widened so max code does not wrap.
  function automatic logic [CODE_W-1:0] quarter(input logic [CODE_W-1:0] code);
    logic [CODE_W:0] sum;
    sum = {1'b0, code} + (CODE_W+1)'(1);
    return sum[CODE_W:1];
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      phase_meta <= 1'b0;
      phase_s    <= 1'b0;
      HALF_CODE  <= '0;
      DEL_CODE   <= '0;
      DQSDEL     <= 1'b0;
      LOCK       <= 1'b0;
      ERR        <= 1'b0;
      BUSY       <= 1'b0;
`ifdef DLLDELAY_CAL_TRACK_EN
      track_cnt  <= '0;
`endif
    end else begin
      phase_meta <= PHASE_IN;
      phase_s    <= phase_meta;
      if (CAL_START) begin
        state      <= ST_SETTLE;
        settle_cnt <= SETTLE_LOAD;
        HALF_CODE  <= '0;
        DEL_CODE   <= '0;
        DQSDEL     <= 1'b0;
        LOCK       <= 1'b0;
        ERR        <= 1'b0;
        BUSY       <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_SETTLE: begin
            if (settle_cnt == '0) state <= ST_CHECK;
            else settle_cnt <= settle_cnt - 1'b1;
          end
          ST_CHECK: begin
            // Detector already past half a period at zero delay, or never reached it.
            if ((phase_s && HALF_CODE == '0) || (!phase_s && HALF_CODE == CODE_MAX)) begin
              state    <= ST_FAIL;
              DEL_CODE <= '0;
              DQSDEL   <= 1'b0;
              LOCK     <= 1'b0;
              ERR      <= 1'b1;
              BUSY     <= 1'b0;
            end else if (phase_s) begin
              state    <= ST_LOCKED;
              DEL_CODE <= quarter(HALF_CODE);
              DQSDEL   <= 1'b1;
              LOCK     <= 1'b1;
              BUSY     <= 1'b0;
`ifdef DLLDELAY_CAL_TRACK_EN
              track_cnt <= '0;
`endif
            end else begin
              state      <= ST_SETTLE;
              settle_cnt <= SETTLE_LOAD;
              HALF_CODE  <= HALF_CODE + CODE_ONE;
            end
          end
          ST_LOCKED: begin
`ifdef DLLDELAY_CAL_TRACK_EN
            if (track_cnt == TRACK_LAST) begin
              track_cnt <= '0;
              if (!HOLD) begin
                if (phase_s && HALF_CODE > CODE_ONE) begin
                  HALF_CODE <= HALF_CODE - CODE_ONE;
                  DEL_CODE  <= quarter(HALF_CODE - CODE_ONE);
                end else if (!phase_s && HALF_CODE != CODE_MAX) begin
                  HALF_CODE <= HALF_CODE + CODE_ONE;
                  DEL_CODE  <= quarter(HALF_CODE + CODE_ONE);
                end
              end
            end else begin
              track_cnt <= track_cnt + 1'b1;
            end
`endif
          end
          ST_FAIL: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dll_delay_cal.sv
// tb/tb_dll_delay_cal.sv - table-driven and randomized bench for dll_delay_cal
// Phase detector modelled as PHASE_IN = (HALF_CODE >= threshold) unless forced.
module tb_dll_delay_cal;

  localparam int CW   = 7;
  localparam int SC   = 4;
  localparam int STEP = SC + 1;
  localparam int MAXC = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CAL_START;
  logic          PHASE_IN = 1'b0;
  logic          HOLD;
  logic [CW-1:0] HALF_CODE;
  logic [CW-1:0] DEL_CODE;
  logic          DQSDEL;
  logic          LOCK;
  logic          ERR;
  logic          BUSY;

  int checks = 0;
  int errors = 0;
  int thr    = 1000;
  bit force_en  = 1'b1;
  bit force_val = 1'b0;

  typedef struct {
    int thr;
    int cyc;
    int lock;
    int err;
    int half;
    int del;
  } vec_t;

  vec_t vecs[6];

  dll_delay_cal #(.CODE_W(CW), .SETTLE_CYC(SC), .TRACK_INTERVAL(64)) dut (
    .CLK(CLK), .RST(RST), .CAL_START(CAL_START), .PHASE_IN(PHASE_IN), .HOLD(HOLD),
    .HALF_CODE(HALF_CODE), .DEL_CODE(DEL_CODE), .DQSDEL(DQSDEL), .LOCK(LOCK),
    .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (force_en) PHASE_IN = force_val;
    else PHASE_IN = (int'(HALF_CODE) >= thr);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // First code at or past the threshold wins; none in range or code 0 means failure.
  function automatic void model(input int t, output int cyc, output int lock,
                                output int err, output int half, output int del);
    if (t == 0) begin
      cyc = STEP; lock = 0; err = 1; half = 0; del = 0;
    end else if (t > MAXC) begin
      cyc = (MAXC + 1) * STEP; lock = 0; err = 1; half = MAXC; del = 0;
    end else begin
      cyc = (t + 1) * STEP; lock = 1; err = 0; half = t; del = (t + 1) / 2;
    end
  endfunction

  task automatic check_all_zero(input string nm);
    chk({nm, "_half"}, HALF_CODE, 0);
    chk({nm, "_del"}, DEL_CODE, 0);
    chk({nm, "_dqsdel"}, DQSDEL, 0);
    chk({nm, "_lock"}, LOCK, 0);
    chk({nm, "_err"}, ERR, 0);
    chk({nm, "_busy"}, BUSY, 0);
  endtask

  task automatic pulse_start(input int t);
    @(negedge CLK);
    force_en = 1'b0;
    thr = t;
    CAL_START = 1'b1;
    @(posedge CLK);
    #1;
    CAL_START = 1'b0;
  endtask

  task automatic wait_half(input int v, input int bound);
    int n;
    n = 0;
    while (int'(HALF_CODE) != v && n < bound) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("wait_half_reached", HALF_CODE, v);
  endtask

  task automatic run_cal(input string nm, input int t, input int exp_cyc, input int exp_lock,
                         input int exp_err, input int exp_half, input int exp_del);
    int n;
    bit done;
    bit busy_ok;
    pulse_start(t);
    chk({nm, "_start_half"}, HALF_CODE, 0);
    chk({nm, "_start_busy"}, BUSY, 1);
    chk({nm, "_start_lock"}, LOCK, 0);
    chk({nm, "_start_dqsdel"}, DQSDEL, 0);
    n = 0;
    done = 1'b0;
    busy_ok = 1'b1;
    while (!done && n < 700) begin
      @(posedge CLK);
      #1;
      n++;
      if (LOCK || ERR) done = 1'b1;
      else if (!BUSY) busy_ok = 1'b0;
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_cycles"}, n, exp_cyc);
    chk({nm, "_busy_during"}, busy_ok, 1);
    chk({nm, "_lock"}, LOCK, exp_lock);
    chk({nm, "_dqsdel"}, DQSDEL, exp_lock);
    chk({nm, "_err"}, ERR, exp_err);
    chk({nm, "_half"}, HALF_CODE, exp_half);
    chk({nm, "_del"}, DEL_CODE, exp_del);
    chk({nm, "_busy_end"}, BUSY, 0);
  endtask

  initial begin
    int c, l, e, h, d, t;
    vecs[0] = '{thr: 20,   cyc: 105, lock: 1, err: 0, half: 20,  del: 10};
    vecs[1] = '{thr: 21,   cyc: 110, lock: 1, err: 0, half: 21,  del: 11};
    vecs[2] = '{thr: 0,    cyc: 5,   lock: 0, err: 1, half: 0,   del: 0};
    vecs[3] = '{thr: 1000, cyc: 640, lock: 0, err: 1, half: 127, del: 0};
    vecs[4] = '{thr: 1,    cyc: 10,  lock: 1, err: 0, half: 1,   del: 1};
    vecs[5] = '{thr: 127,  cyc: 640, lock: 1, err: 0, half: 127, del: 64};

    RST = 1'b1;
    CAL_START = 1'b0;
    HOLD = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      force_val = 1'($urandom);
      @(posedge CLK);
      #1;
    end
    check_all_zero("idle_toggle");

    for (int i = 0; i < 6; i++)
      run_cal($sformatf("vec%0d", i), vecs[i].thr, vecs[i].cyc, vecs[i].lock,
              vecs[i].err, vecs[i].half, vecs[i].del);

    for (int i = 0; i < 20; i++) begin
      t = (i % 5 == 0) ? int'($urandom_range(125, 140)) : int'($urandom_range(0, 60));
      model(t, c, l, e, h, d);
      run_cal($sformatf("rnd%0d_t%0d", i, t), t, c, l, e, h, d);
    end

    run_cal("trk_lock", 20, 105, 1, 0, 20, 10);
    force_en = 1'b1;
    force_val = 1'b0;
`ifdef DLLDELAY_CAL_TRACK_EN
    repeat (63) @(posedge CLK);
    #1;
    chk("trk_before_half", HALF_CODE, 20);
    @(posedge CLK);
    #1;
    chk("trk_after_half", HALF_CODE, 21);
    chk("trk_after_del", DEL_CODE, 11);
    HOLD = 1'b1;
    repeat (192) @(posedge CLK);
    #1;
    chk("trk_hold_half", HALF_CODE, 21);
    chk("trk_hold_del", DEL_CODE, 11);
    HOLD = 1'b0;
`else
    for (int i = 0; i < 256; i++) begin
      HOLD = 1'($urandom);
      @(posedge CLK);
      #1;
    end
    HOLD = 1'b0;
    chk("frozen_half", HALF_CODE, 20);
    chk("frozen_del", DEL_CODE, 10);
`endif
    chk("trk_lock_kept", LOCK, 1);
    chk("trk_dqsdel_kept", DQSDEL, 1);

    run_cal("relock_from_locked", 21, 110, 1, 0, 21, 11);

    pulse_start(20);
    wait_half(9, 200);
    run_cal("restart_mid", 20, 105, 1, 0, 20, 10);

    pulse_start(20);
    wait_half(15, 200);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_all_zero("rst_mid");
    @(negedge CLK);
    RST = 1'b0;
    run_cal("after_rst", 20, 105, 1, 0, 20, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
